// File: rtl/branch_resolve_stage_if.sv
// Execute-stage branch resolver bundle: upstream beat, EX/MEM slot, front-end redirect/flush.
// The slave modport is the resolver; master is whatever drives it (decode side plus downstream).
interface branch_resolve_stage_if #(
    parameter int XLEN = 64
);
    logic            in_valid;
    logic            in_ready;
    logic            in_is_branch;
    logic [2:0]      in_funct3;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_imm;
    logic [XLEN-1:0] in_rs1;
    logic [XLEN-1:0] in_rs2;
    logic            in_lt;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic            out_taken;
    logic [XLEN-1:0] out_target;

    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            flush;
    logic            misalign_exc;
    logic            unsupported;

    modport master (
        output in_valid, in_is_branch, in_funct3, in_pc, in_imm, in_rs1, in_rs2, in_lt,
        output out_ready,
        input  in_ready,
        input  out_valid, out_pc, out_taken, out_target,
        input  redirect_valid, redirect_pc, flush, misalign_exc, unsupported
    );

    modport slave (
        input  in_valid, in_is_branch, in_funct3, in_pc, in_imm, in_rs1, in_rs2, in_lt,
        input  out_ready,
        output in_ready,
        output out_valid, out_pc, out_taken, out_target,
        output redirect_valid, redirect_pc, flush, misalign_exc, unsupported
    );
endinterface

// File: rtl/branch_resolve_stage.sv
// Resolves BEQ/BNE/BLT/BGE, redirects fetch and squashes wrong-path beats for FLUSH_CYCLES cycles.
// Latency 1 cycle accept->slot/redirect; slot stalls via in_ready = !out_valid | out_ready.
module branch_resolve_stage #(
    parameter int XLEN         = 64,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    branch_resolve_stage_if.slave bus
);
    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_BNE     = 3'b001;
    localparam logic [2:0] F3_BLT     = 3'b100;
    localparam logic [2:0] F3_BGE     = 3'b101;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] out_pc_q, out_pc_d;
    logic            out_taken_q, out_taken_d;
    logic [XLEN-1:0] out_target_q, out_target_d;
    logic            redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
    logic            misalign_q, misalign_d;
    logic            unsupported_q, unsupported_d;

    logic            accept;
    logic            live;
    logic            eq;
    logic            supported;
    logic            cond;
    logic            raw_taken;
    logic            misaligned;
    logic            taken;
    logic [XLEN-1:0] target;

    assign bus.in_ready = !out_valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;
    // Beats accepted during FLUSH are wrong-path: consumed but otherwise ignored.
    assign live         = accept && (state_q == IDLE);

    always_comb begin
        eq        = (bus.in_rs1 == bus.in_rs2);
        supported = 1'b1;
        cond      = 1'b0;
        case (bus.in_funct3)
            F3_BEQ:  cond = eq;
            F3_BNE:  cond = !eq;
            F3_BLT:  cond = bus.in_lt;
            F3_BGE:  cond = !bus.in_lt;
            default: supported = 1'b0;
        endcase
        target     = bus.in_pc + bus.in_imm;
        raw_taken  = bus.in_is_branch && supported && cond;
        misaligned = raw_taken && (target[1:0] != 2'b00);
        taken      = raw_taken && !misaligned;
    end

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        out_valid_d      = out_valid_q;
        out_pc_d         = out_pc_q;
        out_taken_d      = out_taken_q;
        out_target_d     = out_target_q;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        misalign_d       = 1'b0;
        unsupported_d    = 1'b0;

        if (live) begin
            out_valid_d   = 1'b1;
            out_pc_d      = bus.in_pc;
            out_taken_d   = taken;
            out_target_d  = target;
            misalign_d    = misaligned;
            unsupported_d = bus.in_is_branch && !supported;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (live && taken) begin
                    redirect_valid_d = 1'b1;
                    redirect_pc_d    = target;
                    state_d          = FLUSH;
                    cnt_d            = FLUSH_INIT;
                end
            end
            FLUSH: begin
                // Counts down regardless of stalls so the squash window is fixed length.
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            cnt_q            <= 4'd0;
            out_valid_q      <= 1'b0;
            out_pc_q         <= '0;
            out_taken_q      <= 1'b0;
            out_target_q     <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            misalign_q       <= 1'b0;
            unsupported_q    <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            out_valid_q      <= out_valid_d;
            out_pc_q         <= out_pc_d;
            out_taken_q      <= out_taken_d;
            out_target_q     <= out_target_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            misalign_q       <= misalign_d;
            unsupported_q    <= unsupported_d;
        end
    end

    assign bus.out_valid      = out_valid_q;
    assign bus.out_pc         = out_pc_q;
    assign bus.out_taken      = out_taken_q;
    assign bus.out_target     = out_target_q;
    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.flush          = (state_q == FLUSH);
    assign bus.misalign_exc   = misalign_q;
    assign bus.unsupported    = unsupported_q;
endmodule
